stats_req_scheduler: RTL and testbench
======================================

// Module: stats_req_scheduler
// PURPOSE
// Shares the single tracker requester of the stats manager between NUM_SRC clients.
// Arbitrates round-robin among pending requester_input descriptors.
// Splits each granted [start_addr,end_addr] range into chunks of at most CHUNK_ENTRIES.
// Issues the chunks one at a time downstream, waiting for each chunk's completion before the next.
// PARAMETERS
// NUM_SRC         4     number of requesting clients (>=2)
// CHUNK_ENTRIES   64    max tracker entries per downstream request (power of 2, <=2^TRACKER_ADDR_W)
// TIMEOUT_CYCLES  4096  max cycles waiting for chunk completion before abort
// PORTS
// clk           in   1                 clock
// rst           in   1                 synchronous, active-high reset
// src_req_val   in   NUM_SRC           per-client descriptor valid
// src_req       in   NUM_SRC x requester_input  per-client descriptor
// src_req_rdy   out  NUM_SRC           one-hot accept; held 1 cycle on grant
// src_done      out  NUM_SRC           one-cycle pulse: granted request finished
// src_err       out  1                 qualifies src_done: 1 = aborted by timeout
// out_req_val   out  1                 chunk request valid
// out_req       out  requester_input   chunk: dst/fbits/req_type from client, chunked addrs
// out_req_rdy   in   1                 tracker requester accepts chunk
// out_chunk_done in  1                 pulse: tracker requester finished current chunk
// busy          out  1                 1 whenever state != IDLE
// BEHAVIOUR
// - Reset: state=IDLE, rr_ptr=0, all outputs 0, out_req=0; abandons any transfer without pulses.
// - IDLE: if any src_req_val, grant first valid index at/after rr_ptr (wrapping).
//   Assert src_req_rdy[g] same cycle, latch descriptor, set rr_ptr=g+1 mod NUM_SRC, go ISSUE.
//   With no valid source, remain in IDLE.
// - Empty range (end_addr < start_addr): no downstream issue; src_done[g] pulse next cycle, src_err=0, back to IDLE.
// - ISSUE: out_req_val=1.
//   out_req.start_addr = cur.
//   out_req.end_addr = min(cur+CHUNK_ENTRIES-1, end_addr).
//   Compute in TRACKER_ADDR_W+1 bits so end_addr = all-ones never wraps.
//   out_req fields stable while val && !rdy. On val&&rdy go WAIT; timer cleared.
// - WAIT: timer increments every cycle.
//   On out_chunk_done: if chunk end == end_addr go DONE, else cur = chunk end+1, go ISSUE.
//   Chunk completions are strictly serialised, so at most one chunk is outstanding.
//   Timer reaching TIMEOUT_CYCLES-1 without done: go DONE with err=1.
//   If done and timeout fall in the same cycle, done wins (err=0).
// - out_chunk_done outside WAIT is ignored.
// - DONE: one cycle; src_done[g]=1, src_err=err; then IDLE.
//   A new grant is possible the cycle after DONE, not the same cycle.
// - Latency: grant -> first out_req_val = 1 cycle.
//   chunk_done -> next out_req_val = 1 cycle.
//   last chunk_done -> src_done = 1 cycle.
// - Source descriptor changes after grant are ignored (latched copy used).
// STRUCTURE
// - stats_manager_pkg gains:
//   - typedef enum logic [2:0] stats_sched_state_e {IDLE, ISSUE, WAIT, DONE};
//   - localparam STATS_CHUNK_ENTRIES = 64;
//   - localparam STATS_SCHED_TIMEOUT = 4096.
// - Sub-module stats_rr_arb (NUM_SRC): req vector + ptr -> one-hot grant + index, purely combinational.
// - requester_input and tracker_req_type are reused unchanged from the packages.
// TESTING
// - Single src0, start=0x0010, end=0x0010 -> one out_req {0x10,0x10}; chunk_done -> src_done[0] pulse, src_err=0.
// - src1, start=0, end=149, CHUNK=64 -> chunks {0,63},{64,127},{128,149} in order, each only after chunk_done.
//   src_done[1] follows the third done.
// - src0..3 all valid continuously -> grants 0,1,2,3,0; rr_ptr wraps.
//   Each src_req_rdy is a single-cycle pulse.
// - Range start=2^W-8, end=2^W-1 (all-ones) -> single chunk {2^W-8, 2^W-1}, no wrap to 0, done cleanly.
// - out_req_rdy held 0 for 10 cycles -> out_req stable.
//   In WAIT, no chunk_done for TIMEOUT_CYCLES -> src_done pulse, src_err=1, IDLE.
//   Done and timeout in the same cycle -> src_err=0.
// - start=0x20, end=0x1F -> no out_req_val, src_done pulse.
//   rst asserted mid-WAIT -> all outputs 0 next cycle, no src_done, fresh grant afterwards from rr_ptr=0.

Source files
------------

// File: rtl/stats_req_scheduler_pkg.sv
// Shared types and constants for the stats manager tracker request scheduler.
package stats_req_scheduler_pkg;

  localparam int TRACKER_ADDR_W      = 16;
  localparam int STATS_CHUNK_ENTRIES = 64;
  localparam int STATS_SCHED_TIMEOUT = 4096;

  typedef enum logic [1:0] {
    TRK_READ       = 2'd0,
    TRK_CLEAR      = 2'd1,
    TRK_READ_CLEAR = 2'd2,
    TRK_RSVD       = 2'd3
  } tracker_req_type;

  typedef struct packed {
    logic [3:0]                dst;
    logic [7:0]                fbits;
    tracker_req_type           req_type;
    logic [TRACKER_ADDR_W-1:0] start_addr;
    logic [TRACKER_ADDR_W-1:0] end_addr;
  } requester_input;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3
  } stats_sched_state_e;

  // Last address of the chunk starting at cur: min(cur+span, last), evaluated
  // one bit wider so a range ending at all-ones never wraps back to zero.
  function automatic logic [TRACKER_ADDR_W-1:0] chunk_last(
    input logic [TRACKER_ADDR_W-1:0] cur,
    input logic [TRACKER_ADDR_W-1:0] last,
    input logic [TRACKER_ADDR_W:0]   span
  );
    logic [TRACKER_ADDR_W:0] lim;
    lim = {1'b0, cur} + span;
    if (lim > {1'b0, last}) begin
      return last;
    end else begin
      return lim[TRACKER_ADDR_W-1:0];
    end
  endfunction

endpackage

// File: rtl/stats_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module stats_rr_arb #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_SRC-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               vld_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan NUM_SRC positions starting at ptr; the first asserted request wins.
  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    vld_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= NUM_SRC) begin
        cand = cand - NUM_SRC;
      end else begin
        cand = cand + 0;
      end
      cand_idx = cand[IDX_W-1:0];
      if (!vld_o && req_i[cand_idx]) begin
        vld_o           = 1'b1;
        idx_o           = cand_idx;
        gnt_o[cand_idx] = 1'b1;
      end else begin
        vld_o = vld_o;
      end
    end
  end

endmodule

// File: rtl/stats_req_scheduler.sv
// Shares the stats manager's single tracker requester among NUM_SRC clients:
// round-robin grant, split the granted range into chunks, issue them one at a
// time and wait for each completion (with timeout) before the next.
module stats_req_scheduler
  import stats_req_scheduler_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int CHUNK_ENTRIES  = STATS_CHUNK_ENTRIES,
  parameter int TIMEOUT_CYCLES = STATS_SCHED_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SRC-1:0]           src_req_val,
  input  requester_input [NUM_SRC-1:0] src_req,
  output logic [NUM_SRC-1:0]           src_req_rdy,
  output logic [NUM_SRC-1:0]           src_done,
  output logic                         src_err,
  output logic                         out_req_val,
  output requester_input               out_req,
  input  logic                         out_req_rdy,
  input  logic                         out_chunk_done,
  output logic                         busy
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TRACKER_ADDR_W:0] SPAN     = (TRACKER_ADDR_W+1)'(CHUNK_ENTRIES - 1);
  localparam logic [TMR_W-1:0]        TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(NUM_SRC - 1);

  stats_sched_state_e        state_q;
  logic [IDX_W-1:0]          rr_ptr_q;
  logic [IDX_W-1:0]          gidx_q;
  logic [TRACKER_ADDR_W-1:0] last_q;
  logic [TMR_W-1:0]          timer_q;
  logic                      out_req_val_q;
  requester_input            out_req_q;
  logic [NUM_SRC-1:0]        src_done_q;
  logic                      src_err_q;

  logic [NUM_SRC-1:0]        arb_gnt_s;
  logic [IDX_W-1:0]          arb_idx_s;
  logic                      arb_vld_s;
  requester_input            gnt_desc_s;
  logic [TRACKER_ADDR_W-1:0] first_last_s;
  logic [TRACKER_ADDR_W-1:0] next_start_s;
  logic [TRACKER_ADDR_W-1:0] next_last_s;
  logic [NUM_SRC-1:0]        gidx_oh_s;

  stats_rr_arb #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i (src_req_val),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt_s),
    .idx_o (arb_idx_s),
    .vld_o (arb_vld_s)
  );

  // Grant-side descriptor and chunk boundaries for the first and following chunks.
  always_comb begin
    gnt_desc_s   = src_req[arb_idx_s];
    first_last_s = chunk_last(gnt_desc_s.start_addr, gnt_desc_s.end_addr, SPAN);
    next_start_s = out_req_q.end_addr + 16'd1;
    next_last_s  = chunk_last(next_start_s, last_q, SPAN);
    gidx_oh_s    = '0;
    gidx_oh_s[gidx_q] = 1'b1;
  end

  // Accept strobe is only offered from IDLE, and never while reset is held.
  always_comb begin
    if (state_q == IDLE && !rst) begin
      src_req_rdy = arb_gnt_s;
    end else begin
      src_req_rdy = '0;
    end
  end

  assign out_req_val = out_req_val_q;
  assign out_req     = out_req_q;
  assign src_done    = src_done_q;
  assign src_err     = src_err_q;
  assign busy        = (state_q != IDLE);

  // Scheduler FSM with registered request and completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      gidx_q        <= '0;
      last_q        <= '0;
      timer_q       <= '0;
      out_req_val_q <= 1'b0;
      out_req_q     <= '0;
      src_done_q    <= '0;
      src_err_q     <= 1'b0;
    end else begin
      src_done_q <= '0;
      src_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_vld_s) begin
            gidx_q   <= arb_idx_s;
            last_q   <= gnt_desc_s.end_addr;
            rr_ptr_q <= (arb_idx_s == IDX_LAST) ? '0 : arb_idx_s + 1'b1;
            if (gnt_desc_s.end_addr < gnt_desc_s.start_addr) begin
              // Empty range: nothing to issue, report completion straight away.
              state_q    <= DONE;
              src_done_q <= arb_gnt_s;
            end else begin
              state_q            <= ISSUE;
              out_req_val_q      <= 1'b1;
              out_req_q          <= gnt_desc_s;
              out_req_q.end_addr <= first_last_s;
            end
          end
        end
        ISSUE: begin
          if (out_req_rdy) begin
            out_req_val_q <= 1'b0;
            timer_q       <= '0;
            state_q       <= WAIT;
          end
        end
        WAIT: begin
          if (out_chunk_done) begin
            if (out_req_q.end_addr == last_q) begin
              state_q    <= DONE;
              src_done_q <= gidx_oh_s;
            end else begin
              state_q              <= ISSUE;
              out_req_val_q        <= 1'b1;
              out_req_q.start_addr <= next_start_s;
              out_req_q.end_addr   <= next_last_s;
            end
          end else if (timer_q == TMR_LAST) begin
            state_q    <= DONE;
            src_done_q <= gidx_oh_s;
            src_err_q  <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stats_req_scheduler.sv
// Randomized self-checking bench for stats_req_scheduler against a
// transaction-level model (round-robin pick, arithmetic chunk list).
module tb_stats_req_scheduler;
  import stats_req_scheduler_pkg::*;

  localparam int NS = 4;
  localparam int CH = 64;
  localparam int TO = 4096;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NS-1:0]           src_req_val;
  requester_input [NS-1:0] src_req;
  logic [NS-1:0]           src_req_rdy;
  logic [NS-1:0]           src_done;
  logic                    src_err;
  logic                    out_req_val;
  requester_input          out_req;
  logic                    out_req_rdy;
  logic                    out_chunk_done;
  logic                    busy;

  int checks = 0;
  int errors = 0;
  int rr_m   = 0;

  stats_req_scheduler #(
    .NUM_SRC        (NS),
    .CHUNK_ENTRIES  (CH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .src_req_val    (src_req_val),
    .src_req        (src_req),
    .src_req_rdy    (src_req_rdy),
    .src_done       (src_done),
    .src_err        (src_err),
    .out_req_val    (out_req_val),
    .out_req        (out_req),
    .out_req_rdy    (out_req_rdy),
    .out_chunk_done (out_chunk_done),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven 2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic requester_input make_desc(input int lo, input int hi);
    requester_input d;
    d.dst        = 4'($urandom);
    d.fbits      = 8'($urandom);
    d.req_type   = tracker_req_type'(2'($urandom));
    d.start_addr = 16'(lo);
    d.end_addr   = 16'(hi);
    return d;
  endfunction

  function automatic requester_input rand_desc();
    int lo;
    int len;
    lo  = int'($urandom_range(1, 16'hFF00));
    len = int'($urandom_range(0, 200));
    return make_desc(lo, lo + len - 1);
  endfunction

  function automatic int pick(input logic [NS-1:0] m, input int ptr);
    for (int k = 0; k < NS; k++) begin
      if (m[(ptr + k) % NS]) return (ptr + k) % NS;
    end
    return -1;
  endfunction

  // mode: 0 normal, 1 timeout, 2 done on the final timeout cycle,
  //       3 reset mid-wait, 4 ready held low for 10 cycles
  task automatic xfer(input logic [NS-1:0] mask, input int mode);
    int             g;
    requester_input d;
    int             lo_q[$];
    int             hi_q[$];
    logic           exp_err;
    bit             aborted;
    src_req_val = mask;
    #1;
    g = pick(mask, rr_m);
    check_eq("idle_busy", 64'(busy), 64'd0);
    check_eq("idle_done", 64'(src_done), 64'd0);
    check_eq("grant", 64'(src_req_rdy), 64'(NS'(1) << g));
    d = src_req[g];
    for (int a = int'(d.start_addr); a <= int'(d.end_addr); a += CH) begin
      lo_q.push_back(a);
      hi_q.push_back((a + CH - 1 > int'(d.end_addr)) ? int'(d.end_addr) : a + CH - 1);
    end
    step();
    rr_m        = (g + 1) % NS;
    src_req[g]  = rand_desc();
    src_req_val = NS'($urandom);
    exp_err     = 1'b0;
    aborted     = 1'b0;
    while (lo_q.size() > 0 && !aborted) begin
      requester_input e;
      int             n;
      int             w;
      e            = d;
      e.start_addr = 16'(lo_q.pop_front());
      e.end_addr   = 16'(hi_q.pop_front());
      #1;
      check_eq("issue_val", 64'(out_req_val), 64'd1);
      check_eq("issue_req", 64'(out_req), 64'(e));
      check_eq("issue_rdy0", 64'(src_req_rdy), 64'd0);
      check_eq("issue_busy", 64'(busy), 64'd1);
      n = (mode == 4) ? 10 : int'($urandom_range(0, 3));
      for (int i = 0; i < n; i++) begin
        out_chunk_done = 1'($urandom);
        step();
        #1;
        check_eq("hold_val", 64'(out_req_val), 64'd1);
        check_eq("hold_req", 64'(out_req), 64'(e));
      end
      out_chunk_done = 1'b0;
      out_req_rdy    = 1'b1;
      step();
      out_req_rdy = 1'b0;
      case (mode)
        1:       w = TO;
        2:       w = TO - 1;
        3:       w = 3;
        default: w = int'($urandom_range(0, 6));
      endcase
      for (int i = 0; i < w; i++) begin
        #1;
        check_eq("wait_val", 64'(out_req_val), 64'd0);
        check_eq("wait_done", 64'(src_done), 64'd0);
        step();
      end
      if (mode == 3) begin
        rst            = 1'b1;
        step();
        #1;
        check_eq("rst_done", 64'(src_done), 64'd0);
        check_eq("rst_err", 64'(src_err), 64'd0);
        check_eq("rst_val", 64'(out_req_val), 64'd0);
        check_eq("rst_req", 64'(out_req), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_rdy", 64'(src_req_rdy), 64'd0);
        rst  = 1'b0;
        rr_m = 0;
        return;
      end else if (mode == 1) begin
        aborted = 1'b1;
        exp_err = 1'b1;
      end else begin
        out_chunk_done = 1'b1;
        step();
        out_chunk_done = 1'b0;
      end
    end
    #1;
    check_eq("done_pulse", 64'(src_done), 64'(NS'(1) << g));
    check_eq("done_err", 64'(src_err), 64'(exp_err));
    check_eq("done_val", 64'(out_req_val), 64'd0);
    check_eq("done_rdy0", 64'(src_req_rdy), 64'd0);
    check_eq("done_busy", 64'(busy), 64'd1);
    src_req_val = '0;
    step();
  endtask

  initial begin
    rst            = 1'b1;
    src_req_val    = '0;
    out_req_rdy    = 1'b0;
    out_chunk_done = 1'b0;
    for (int i = 0; i < NS; i++) src_req[i] = rand_desc();
    repeat (3) step();
    #1;
    check_eq("reset_val", 64'(out_req_val), 64'd0);
    check_eq("reset_req", 64'(out_req), 64'd0);
    check_eq("reset_done", 64'(src_done), 64'd0);
    check_eq("reset_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    step();

    src_req[0] = make_desc(16'h0010, 16'h0010);
    xfer(4'b0001, 0);
    src_req[1] = make_desc(0, 149);
    xfer(4'b0010, 0);
    src_req[2] = make_desc(16'hFFF8, 16'hFFFF);
    xfer(4'b0100, 4);
    src_req[3] = make_desc(16'h0020, 16'h001F);
    xfer(4'b1000, 0);
    src_req[0] = make_desc(16'h0100, 16'h0105);
    xfer(4'b0001, 1);
    src_req[1] = make_desc(16'h0200, 16'h0207);
    xfer(4'b0010, 2);
    src_req[2] = make_desc(16'h0300, 16'h03A0);
    xfer(4'b0100, 3);
    for (int i = 0; i < 5; i++) xfer(4'b1111, 0);
    for (int i = 0; i < 30; i++) xfer(NS'($urandom_range(1, (1 << NS) - 1)), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
